// File: rtl/oam_dma_engine.sv
// rtl/oam_dma_engine.sv - sprite attribute memory DMA engine, 1 byte/cycle while granted.
// Optional OAM_DMA_ECHO_REMAP_EN: pages E0..FF fetch from page-0x20.
module oam_dma_engine #(
    parameter logic [15:0] OAM_BASE     = 16'hFE00,
    parameter int          OAM_BYTES    = 160,
    parameter logic [15:0] DMA_REG_ADDR = 16'hFF46,
    parameter int          ADDR_W       = 16,
    parameter int          DATA_W       = 8
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_reg_wr,
    input  logic [ADDR_W-1:0] i_reg_addr,
    input  logic [DATA_W-1:0] i_reg_wdata,
    output logic [DATA_W-1:0] o_reg_rdata,
    output logic              o_bus_req,
    input  logic              i_bus_gnt,
    output logic              o_rd_en,
    output logic [ADDR_W-1:0] o_rd_addr,
    input  logic [DATA_W-1:0] i_rd_data,
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [DATA_W-1:0] o_wr_data,
    output logic              o_busy,
    output logic              o_done
);

    localparam int IDX_W = $clog2(OAM_BYTES + 1);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_XFER, S_DRAIN, S_DONE} state_t;

    state_t            r_state;
    logic [DATA_W-1:0] r_page;
    logic [DATA_W-1:0] r_reg_rdata;
    logic [IDX_W-1:0]  r_rd_idx;
    logic [IDX_W-1:0]  r_wr_idx;
    logic              r_pend;
    logic              r_hold_vld;
    logic [DATA_W-1:0] r_hold;
    logic              r_bus_req;
    logic              r_busy;
    logic              r_done;

    logic              w_start;
    logic              w_active;
    logic              w_rd;
    logic              w_wr;
    logic              w_last_rd;
    logic              w_last_wr;
    logic [DATA_W-1:0] w_src_page;

    assign w_start   = i_reg_wr && (i_reg_addr == DMA_REG_ADDR);
    assign w_active  = (r_state == S_XFER) || (r_state == S_DRAIN);
    assign w_rd      = (r_state == S_XFER) && i_bus_gnt;
    // r_pend and r_hold_vld are never both set: a held byte implies no read last cycle.
    assign w_wr      = w_active && i_bus_gnt && (r_pend || r_hold_vld);
    assign w_last_rd = w_rd && (r_rd_idx == IDX_W'(OAM_BYTES - 1));
    assign w_last_wr = w_wr && (r_wr_idx == IDX_W'(OAM_BYTES - 1));

`ifdef OAM_DMA_ECHO_REMAP_EN
    assign w_src_page = (r_page >= 8'hE0) ? (r_page - 8'h20) : r_page;
`else
    assign w_src_page = r_page;
`endif

    assign o_rd_en     = w_rd;
    assign o_rd_addr   = w_rd ? {w_src_page, 8'(r_rd_idx)} : '0;
    assign o_wr_en     = w_wr;
    assign o_wr_addr   = w_wr ? (OAM_BASE + ADDR_W'(r_wr_idx)) : '0;
    assign o_wr_data   = w_wr ? (r_hold_vld ? r_hold : i_rd_data) : '0;
    assign o_reg_rdata = r_reg_rdata;
    assign o_bus_req   = r_bus_req;
    assign o_busy      = r_busy;
    assign o_done      = r_done;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_page      <= '0;
            r_reg_rdata <= '0;
            r_rd_idx    <= '0;
            r_wr_idx    <= '0;
            r_pend      <= 1'b0;
            r_hold_vld  <= 1'b0;
            r_hold      <= '0;
            r_bus_req   <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_rd) r_rd_idx <= r_rd_idx + IDX_W'(1);
            if (w_wr) r_wr_idx <= r_wr_idx + IDX_W'(1);
            if (w_active) begin
                if (i_bus_gnt) begin
                    r_pend <= w_rd;
                    if (w_wr) r_hold_vld <= 1'b0;
                end else if (r_pend) begin
                    r_hold     <= i_rd_data;
                    r_hold_vld <= 1'b1;
                    r_pend     <= 1'b0;
                end
            end
            case (r_state)
                S_IDLE:  ;
                S_REQ:   if (i_bus_gnt) r_state <= S_XFER;
                S_XFER:  if (w_last_rd) r_state <= S_DRAIN;
                S_DRAIN: if (w_last_wr) begin
                    r_state   <= S_DONE;
                    r_bus_req <= 1'b0;
                    r_busy    <= 1'b0;
                    r_done    <= 1'b1;
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
            // A start overrides everything above, including a completing transfer.
            if (w_start) begin
                r_page      <= i_reg_wdata;
                r_reg_rdata <= i_reg_wdata;
                r_rd_idx    <= '0;
                r_wr_idx    <= '0;
                r_pend      <= 1'b0;
                r_hold_vld  <= 1'b0;
                r_bus_req   <= 1'b1;
                r_busy      <= 1'b1;
                r_done      <= 1'b0;
                r_state     <= (w_active || (r_state == S_REQ && i_bus_gnt)) ? S_XFER : S_REQ;
            end
        end
    end

endmodule

// File: tb/tb_oam_dma_engine.sv
// tb/tb_oam_dma_engine.sv - directed bench for oam_dma_engine with bus source and OAM sink models.
module tb_oam_dma_engine;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        reg_wr = 1'b0;
    logic [15:0] reg_addr = '0;
    logic [7:0]  reg_wdata = '0;
    logic [7:0]  reg_rdata;
    logic        bus_req;
    logic        bus_gnt = 1'b0;
    logic        rd_en;
    logic [15:0] rd_addr;
    logic [7:0]  rd_data = '0;
    logic        wr_en;
    logic [15:0] wr_addr;
    logic [7:0]  wr_data;
    logic        busy;
    logic        done;

    int n_pass = 0;
    int n_total = 0;

    logic [7:0]  oam [0:159];
    int          rd_cnt, wr_cnt, act_cnt, viol, bad_addr, done_cnt;
    logic [15:0] first_rd, last_rd, first_wr, last_wr;

    oam_dma_engine dut (
        .i_clk(clk), .i_reset(reset), .i_reg_wr(reg_wr), .i_reg_addr(reg_addr),
        .i_reg_wdata(reg_wdata), .o_reg_rdata(reg_rdata), .o_bus_req(bus_req),
        .i_bus_gnt(bus_gnt), .o_rd_en(rd_en), .o_rd_addr(rd_addr), .i_rd_data(rd_data),
        .o_wr_en(wr_en), .o_wr_addr(wr_addr), .o_wr_data(wr_data), .o_busy(busy), .o_done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] src_byte(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    // Source memory: data appears the cycle after the read strobe.
    initial begin
        logic        p;
        logic [15:0] a;
        forever begin
            @(negedge clk);
            p = rd_en;
            a = rd_addr;
            @(posedge clk);
            #1;
            if (p) rd_data = src_byte(a);
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rd_en) begin
                if (rd_cnt == 0) first_rd = rd_addr;
                last_rd = rd_addr;
                rd_cnt++;
            end
            if (wr_en) begin
                if (wr_cnt == 0) first_wr = wr_addr;
                last_wr = wr_addr;
                wr_cnt++;
                if (wr_addr >= 16'hFE00 && wr_addr < 16'hFEA0) oam[wr_addr - 16'hFE00] = wr_data;
                else bad_addr++;
            end
            if (rd_en || wr_en) act_cnt++;
            if (!bus_gnt && (rd_en || wr_en)) viol++;
            if (done) done_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic clear_track();
        rd_cnt = 0; wr_cnt = 0; act_cnt = 0; viol = 0; bad_addr = 0; done_cnt = 0;
        first_rd = '0; last_rd = '0; first_wr = '0; last_wr = '0;
        for (int i = 0; i < 160; i++) oam[i] = 'x;
    endtask

    task automatic reg_write(input logic [15:0] a, input logic [7:0] d);
        reg_wr = 1'b1; reg_addr = a; reg_wdata = d;
        @(posedge clk); #1;
        reg_wr = 1'b0;
    endtask

    function automatic int oam_errs(input logic [7:0] src_page);
        int e = 0;
        for (int i = 0; i < 160; i++)
            if (oam[i] !== src_byte({src_page, 8'(i)})) e++;
        return e;
    endfunction

    // Called in cycle 1 after the start edge; mode 1 drops grant every third cycle.
    task automatic run_until_done(input int mode, input int budget, output int cycles);
        int k = 0;
        cycles = 1;
        while (done !== 1'b1 && cycles < budget) begin
            bus_gnt = (mode == 1) ? ((k % 3) != 2) : 1'b1;
            k++;
            @(posedge clk); #1;
            cycles++;
        end
        check("done_within_budget", done, 1);
    endtask

    initial begin
        int cyc;
        logic [7:0] exp_e3;
        clear_track();
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_bus_req", bus_req, 0);
        check("rst_strobes", {rd_en, wr_en, done}, 0);
        check("rst_rdata", reg_rdata, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Other register addresses are ignored.
        reg_write(16'hFF47, 8'hAA);
        check("ignore_busy", busy, 0);
        check("ignore_rdata", reg_rdata, 0);

        // Page C1, grant tied high.
        clear_track();
        bus_gnt = 1'b1;
        reg_write(16'hFF46, 8'hC1);
        check("t1_req", {bus_req, busy}, 2'b11);
        check("t1_rdata", reg_rdata, 8'hC1);
        run_until_done(0, 400, cyc);
        check("t1_done_cycle", cyc, 163);
        check("t1_done_state", {bus_req, busy}, 2'b00);
        check("t1_first_rd", first_rd, 16'hC100);
        check("t1_last_rd", last_rd, 16'hC19F);
        check("t1_first_wr", first_wr, 16'hFE00);
        check("t1_last_wr", last_wr, 16'hFE9F);
        check("t1_active_cycles", act_cnt, 161);
        check("t1_oam", oam_errs(8'hC1), 0);
        @(posedge clk); #1;
        check("t1_done_pulse", done_cnt, 1);
        check("t1_done_low", done, 0);

        // Grant dropped every third cycle.
        clear_track();
        reg_write(16'hFF46, 8'h37);
        run_until_done(1, 800, cyc);
        bus_gnt = 1'b1;
        check("t2_wr_cnt", wr_cnt, 160);
        check("t2_rd_cnt", rd_cnt, 160);
        check("t2_oam", oam_errs(8'h37), 0);
        check("t2_viol", viol, 0);
        check("t2_bad_addr", bad_addr, 0);

        // Restart with page C2 after 50 bytes written.
        @(posedge clk); #1;
        clear_track();
        reg_write(16'hFF46, 8'hC1);
        cyc = 0;
        while (wr_cnt < 50 && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("t3_reached_50", wr_cnt >= 50, 1);
        reg_write(16'hFF46, 8'hC2);
        check("t3_no_done_yet", done_cnt, 0);
        clear_track();
        check("t3_still_busy", {bus_req, busy}, 2'b11);
        run_until_done(0, 400, cyc);
        @(posedge clk); #1;
        check("t3_first_wr", first_wr, 16'hFE00);
        check("t3_wr_cnt", wr_cnt, 160);
        check("t3_oam", oam_errs(8'hC2), 0);
        check("t3_done_cnt", done_cnt, 1);

        // Reset in the middle of a transfer.
        clear_track();
        reg_write(16'hFF46, 8'hC1);
        cyc = 0;
        while (wr_cnt < 80 && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        check("t4_busy", busy, 0);
        check("t4_bus_req", bus_req, 0);
        check("t4_strobes", {rd_en, wr_en}, 0);
        check("t4_rdata", reg_rdata, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Echo page E3.
`ifdef OAM_DMA_ECHO_REMAP_EN
        exp_e3 = 8'hC3;
`else
        exp_e3 = 8'hE3;
`endif
        clear_track();
        reg_write(16'hFF46, 8'hE3);
        run_until_done(0, 400, cyc);
        check("t5_first_rd", first_rd, {exp_e3, 8'h00});
        check("t5_rdata", reg_rdata, 8'hE3);
        check("t5_oam", oam_errs(exp_e3), 0);
        @(posedge clk); #1;

        // Grant withheld for 20 cycles after start.
        clear_track();
        bus_gnt = 1'b0;
        reg_write(16'hFF46, 8'h10);
        cyc = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus_req !== 1'b1 || busy !== 1'b1) cyc++;
            @(posedge clk); #1;
        end
        check("t6_req_busy_held", cyc, 0);
        check("t6_no_strobes", rd_cnt + wr_cnt, 0);
        run_until_done(0, 400, cyc);
        check("t6_wr_cnt", wr_cnt, 160);
        check("t6_oam", oam_errs(8'h10), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
